// File: rtl/div_unit_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module div_unit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, quo, divisor, a_q;
    logic [CW-1:0]    cnt;
    logic             rem_sel, sign_q, sign_r, bz, ovf;

    // Operand conditioning at acceptance time
    logic             signed_op, a_neg, b_neg, b_zero, overflow, accept;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_abs     = a_neg ? (~a + 1'b1) : a;
    assign b_abs     = b_neg ? (~b + 1'b1) : b;
    assign b_zero    = (b == '0);
    assign overflow  = signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    // done is high in the first IDLE cycle; a start landing there is dropped.
    assign accept    = (state == IDLE) && start && !done;

    // One restoring step: trial subtraction is WIDTH+1 bits, top bit is the borrow.
    logic [WIDTH:0]   shifted, trial;
    logic             fits;

    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign fits    = ~trial[WIDTH];

    // Sign fix-up, RISC-V boundary overrides, then quotient/remainder select
    logic [WIDTH-1:0] quo_s, rem_s, quo_f, rem_f, res_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        quo_s = sign_q ? (~quo + 1'b1) : quo;
        rem_s = sign_r ? (~rem + 1'b1) : rem;
        quo_f = quo_s;
        rem_f = rem_s;
        if (bz) begin
            quo_f = '1;
            rem_f = a_q;
        end else if (ovf) begin
            quo_f = a_q;
            rem_f = '0;
        end
        res_sel = rem_sel ? rem_f : quo_f;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                state_nxt = (b_zero || overflow) ? FIX : CALC;
`else
                state_nxt = CALC;
`endif
            end
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            a_q         <= '0;
            cnt         <= '0;
            rem_sel     <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            bz          <= 1'b0;
            ovf         <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (accept) begin
                a_q     <= a;
                divisor <= b_abs;
                quo     <= a_abs;
                rem     <= '0;
                cnt     <= CW'(WIDTH - 1);
                rem_sel <= op[1];
                sign_q  <= a_neg ^ b_neg;
                sign_r  <= a_neg;
                bz      <= b_zero;
                ovf     <= overflow;
            end
            if (state == CALC) begin
                rem <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], fits};
                cnt <= cnt - 1'b1;
            end
            if (state == FIX) begin
                result      <= res_sel;
                div_by_zero <= bz;
            end
        end
    end

endmodule

// File: tb/tb_div_unit_seq.sv
// Directed self-checking bench for div_unit_seq (WIDTH=32); honours DIV_EARLY_OUT_EN for latency.
module tb_div_unit_seq;

    localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SHORT = 2;
`else
    localparam int LAT_SHORT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    div_unit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Launch one operation; report latency in cycles after start, the result, and pulse/busy shape.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic [W-1:0] res, output logic dz,
                          output logic busy_ok, output logic pulse_ok);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        lat = -1; res = '0; dz = 1'b0; busy_ok = 1'b1; pulse_ok = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                lat = k; res = result; dz = div_by_zero;
                if (busy) busy_ok = 1'b0;
                @(negedge clk);
                pulse_ok = !done;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (result !== '0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] exp_res,
                            input logic exp_dz, input int exp_lat);
        int lat; logic [W-1:0] res; logic dz, bok, pok;
        run_op(o, x, y, lat, res, dz, bok, pok);
        tests++; if (lat !== exp_lat) begin fails++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
        tests++; if (res !== exp_res) begin fails++; $display("FAIL %s_result got %h want %h", name, res, exp_res); end
        tests++; if (dz !== exp_dz) begin fails++; $display("FAIL %s_dz got %b want %b", name, dz, exp_dz); end
        tests++; if (bok !== 1'b1) begin fails++; $display("FAIL %s_busy got %b want 1", name, bok); end
        tests++; if (pok !== 1'b1) begin fails++; $display("FAIL %s_done_pulse got %b want 1", name, pok); end
    endtask

    task automatic test_unsigned;
        check_op("divu", 2'b01, 32'd1127, 32'd56, 32'd20, 1'b0, W + 2);
        check_op("remu", 2'b11, 32'd1127, 32'd56, 32'd7, 1'b0, W + 2);
        check_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b0, W + 2);
    endtask

    task automatic test_signed;
        check_op("div_p_n", 2'b00, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, W + 2);
        check_op("rem_p_n", 2'b10, 32'd7, 32'hFFFF_FFFB, 32'd2, 1'b0, W + 2);
        check_op("div_n_p", 2'b00, 32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFF, 1'b0, W + 2);
        check_op("rem_n_p", 2'b10, 32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFE, 1'b0, W + 2);
        check_op("rem_small", 2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 1'b0, W + 2);
    endtask

    task automatic test_div_zero;
        check_op("div_z", 2'b00, 32'd12323, 32'd0, 32'hFFFF_FFFF, 1'b1, LAT_SHORT);
        check_op("rem_z", 2'b10, 32'd12323, 32'd0, 32'd12323, 1'b1, LAT_SHORT);
        check_op("div_negz", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, LAT_SHORT);
        check_op("rem_negz", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, LAT_SHORT);
        check_op("divu_z", 2'b01, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF, 1'b1, LAT_SHORT);
    endtask

    task automatic test_overflow;
        check_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_SHORT);
        check_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT_SHORT);
        check_op("divu_full", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, W + 2);
    endtask

    // Starts while busy and in the done cycle are dropped; a start one cycle after done is taken.
    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1127; b = 32'd56;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            start = (k == 5);
            if (k == 5) begin op = 2'b11; a = 32'd500; b = 32'd3; end
            if (done) begin
                lat = k;
                tests++; if (result !== 32'd20) begin fails++; $display("FAIL busy_start_result got %h want %h", result, 32'd20); end
                start = 1'b1; op = 2'b01; a = 32'd999; b = 32'd3;
                break;
            end
            @(negedge clk);
        end
        tests++; if (lat !== W + 2) begin fails++; $display("FAIL busy_start_latency got %0d want %0d", lat, W + 2); end
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                lat = k;
                tests++; if (result !== 32'd14) begin fails++; $display("FAIL b2b_result got %h want %h", result, 32'd14); end
                break;
            end
            @(negedge clk);
        end
        tests++; if (lat !== W + 2) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, W + 2); end
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1127; b = 32'd56;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
        tests++; if (result !== '0) begin fails++; $display("FAIL abort_result got %h want 0", result); end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", saw_done); end
        check_op("post_reset", 2'b01, 32'd5, 32'd7, 32'd0, 1'b0, W + 2);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
